// File: rtl/mem_port_arbiter.sv
// Two-port arbiter/sequencer for the shared memory macro: grants IF (port 0) or MEM (port 1),
// runs one access with ready/timeout handling. Define ARB_FIXED_PRIO_EN for port-1-wins ties (default round-robin).
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       req0_i,
    input  logic       we0_i,
    input  logic       req1_i,
    input  logic       we1_i,
    input  logic       mem_ready_i,
    output logic       sel_o,
    output logic       mem_en_o,
    output logic       mem_we_o,
    output logic       ack0_o,
    output logic       ack1_o,
    output logic       err_o,
    output logic       busy_o,
    output logic [1:0] dbg_state_o
);

    // Handshake: a port holds req high until its one-cycle ack; the access itself
    // runs while mem_en_o is high and completes on the first cycle mem_ready_i is sampled high.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t     state_q, state_d;
    logic       sel_q, sel_d;
    logic       en_q, en_d;
    logic       we_q, we_d;
    logic       ack0_q, ack0_d;
    logic       ack1_q, ack1_d;
    logic       err_q, err_d;
    logic       last_q, last_d;
    logic [7:0] cnt_q, cnt_d;
    logic       grant_port;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            sel_q   <= 1'b0;
            en_q    <= 1'b0;
            we_q    <= 1'b0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            err_q   <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            en_q    <= en_d;
            we_q    <= we_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            err_q   <= err_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // Tie-break: only consulted when both ports request in the same IDLE cycle.
    always_comb begin
        grant_port = req1_i;
        if (req0_i && req1_i) begin
`ifdef ARB_FIXED_PRIO_EN
            grant_port = 1'b1;
`else
            grant_port = ~last_q;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        en_d    = en_q;
        we_d    = we_q;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        err_d   = 1'b0;
        last_d  = last_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (req0_i || req1_i) begin
                    sel_d   = grant_port;
                    we_d    = grant_port ? we1_i : we0_i;
                    en_d    = 1'b1;
                    cnt_d   = 8'd0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (mem_ready_i || (cnt_q == TMO_LAST)) begin
                    en_d    = 1'b0;
                    we_d    = 1'b0;
                    ack0_d  = ~sel_q;
                    ack1_d  = sel_q;
                    err_d   = ~mem_ready_i;
                    last_d  = sel_q;
                    state_d = DONE;
                end else if (cnt_q != 8'hFF) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                en_d    = 1'b0;
                we_d    = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    assign sel_o       = sel_q;
    assign mem_en_o    = en_q;
    assign mem_we_o    = we_q;
    assign ack0_o      = ack0_q;
    assign ack1_o      = ack1_q;
    assign err_o       = err_q;
    assign busy_o      = (state_q != IDLE);
    assign dbg_state_o = state_q;

endmodule
